// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_unit
//  Purpose  : Forwarding selects, load-use / branch stall+flush control, and
//             a multi-cycle execute wait FSM with timeout and perf counters.
//  Revision : 1.0
// ============================================================================
module hazard_unit #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MC_TIMEOUT     = 64,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_e,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_e,
  input  logic [REG_ADDR_WIDTH-1:0] rd_e,
  input  logic [1:0]                res_src_e,
  input  logic                      pc_src_e,
  input  logic [REG_ADDR_WIDTH-1:0] rd_m,
  input  logic                      reg_write_m,
  input  logic [REG_ADDR_WIDTH-1:0] rd_w,
  input  logic                      reg_write_w,
  input  logic                      mc_start_e,
  input  logic                      mc_done_e,
  output logic [1:0]                forward_a_e,
  output logic [1:0]                forward_b_e,
  output logic                      stall_f,
  output logic                      stall_d,
  output logic                      stall_e,
  output logic                      flush_d,
  output logic                      flush_e,
  output logic                      mc_error,
  output logic [CNT_WIDTH-1:0]      stall_count,
  output logic [CNT_WIDTH-1:0]      flush_count
);

  localparam int WAIT_W = $clog2(MC_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] C_WAIT_LAST = WAIT_W'(MC_TIMEOUT - 1);
  localparam logic [1:0] C_FWD_RF = 2'b00;
  localparam logic [1:0] C_FWD_W  = 2'b01;
  localparam logic [1:0] C_FWD_M  = 2'b10;
  localparam logic [1:0] C_RES_LOAD = 2'b01;

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_MC_WAIT = 1'b1;

  logic [0:0]           state_q,       state_d;
  logic [WAIT_W-1:0]    wait_cnt_q,    wait_cnt_d;
  logic                 mc_error_q,    mc_error_d;
  logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;
  logic [CNT_WIDTH-1:0] flush_count_q, flush_count_d;

  logic       w_lw;
  logic       w_mc_busy;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;
  logic       w_stall_fd;
  logic       w_flush_d;
  logic       w_flush_e;

  // Memory stage wins over writeback; x0 is never a forwarding source.
  always_comb begin
    w_fwd_a = C_FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs1_e)) begin
      w_fwd_a = C_FWD_M;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs1_e)) begin
      w_fwd_a = C_FWD_W;
    end

    w_fwd_b = C_FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs2_e)) begin
      w_fwd_b = C_FWD_M;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs2_e)) begin
      w_fwd_b = C_FWD_W;
    end
  end

  // While waiting with mc_done_e low, mc_busy=1 masks every flush and forces
  // all stalls, so one set of equations covers both states.
  always_comb begin
    w_lw = (res_src_e == C_RES_LOAD) && (rd_e != '0) &&
           ((rd_e == rs1_d) || (rd_e == rs2_d));

    if (state_q == ST_RUN) begin
      w_mc_busy = mc_start_e && !mc_done_e;
    end else begin
      w_mc_busy = !mc_done_e;
    end

    w_stall_fd = (w_lw && !pc_src_e) || w_mc_busy;
    w_flush_d  = pc_src_e && !w_mc_busy;
    w_flush_e  = (w_lw || pc_src_e) && !w_mc_busy;
  end

  always_comb begin
    forward_a_e = rst ? C_FWD_RF : w_fwd_a;
    forward_b_e = rst ? C_FWD_RF : w_fwd_b;
    stall_f     = !rst && w_stall_fd;
    stall_d     = !rst && w_stall_fd;
    stall_e     = !rst && w_mc_busy;
    flush_d     = !rst && w_flush_d;
    flush_e     = !rst && w_flush_e;
  end

  // Wait FSM: mc_done_e has priority over the timeout in the same cycle.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    mc_error_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mc_start_e && !mc_done_e) begin
          state_d = ST_MC_WAIT;
        end
      end
      ST_MC_WAIT: begin
        if (mc_done_e) begin
          state_d = ST_RUN;
        end else if (wait_cnt_q == C_WAIT_LAST) begin
          state_d    = ST_RUN;
          mc_error_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (stall_f && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
    if (flush_d && (flush_count_q != '1)) begin
      flush_count_d = flush_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      mc_error_q    <= 1'b0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mc_error_q    <= mc_error_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign mc_error    = mc_error_q;
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_unit
//  Purpose  : Directed self-checking bench for hazard_unit.
//  Revision : 1.0
// ============================================================================
module tb_hazard_unit;

  logic       clk;
  logic       rst;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic [1:0] res_src_e;
  logic       pc_src_e, reg_write_m, reg_write_w, mc_start_e, mc_done_e;

  logic [1:0]  forward_a_e, forward_b_e;
  logic        stall_f, stall_d, stall_e, flush_d, flush_e, mc_error;
  logic [31:0] stall_count, flush_count;

  logic [1:0]  s_fwd_a, s_fwd_b;
  logic        s_stall_f, s_stall_d, s_stall_e, s_flush_d, s_flush_e, s_mc_error;
  logic [1:0]  s_stall_count, s_flush_count;

  int n_checks = 0;
  int n_errors = 0;

  hazard_unit #(.REG_ADDR_WIDTH(5), .MC_TIMEOUT(8), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .res_src_e(res_src_e), .pc_src_e(pc_src_e),
    .rd_m(rd_m), .reg_write_m(reg_write_m), .rd_w(rd_w), .reg_write_w(reg_write_w),
    .mc_start_e(mc_start_e), .mc_done_e(mc_done_e),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
    .flush_d(flush_d), .flush_e(flush_e), .mc_error(mc_error),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  // Narrow-counter instance to reach saturation quickly.
  hazard_unit #(.REG_ADDR_WIDTH(5), .MC_TIMEOUT(8), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .res_src_e(res_src_e), .pc_src_e(pc_src_e),
    .rd_m(rd_m), .reg_write_m(reg_write_m), .rd_w(rd_w), .reg_write_w(reg_write_w),
    .mc_start_e(mc_start_e), .mc_done_e(mc_done_e),
    .forward_a_e(s_fwd_a), .forward_b_e(s_fwd_b),
    .stall_f(s_stall_f), .stall_d(s_stall_d), .stall_e(s_stall_e),
    .flush_d(s_flush_d), .flush_e(s_flush_e), .mc_error(s_mc_error),
    .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
    res_src_e = 2'b00; pc_src_e = 1'b0; reg_write_m = 1'b0; reg_write_w = 1'b0;
    mc_start_e = 1'b0; mc_done_e = 1'b0;
  endtask

  task automatic load_use();
    res_src_e = 2'b01; rd_e = 5'd7; rs2_d = 5'd7;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    rst = 1'b1;
    step(); step();

    // Outputs forced low during reset even with matching inputs.
    rs1_e = 5'd5; rd_m = 5'd5; reg_write_m = 1'b1; pc_src_e = 1'b1; load_use();
    #1;
    check("rst_fwd_a", forward_a_e, 2'b00);
    check("rst_flush_d", flush_d, 1'b0);
    check("rst_stall_f", stall_f, 1'b0);
    step();
    check("rst_stall_cnt", stall_count, 0);
    check("rst_flush_cnt", flush_count, 0);
    check("rst_mc_error", mc_error, 1'b0);
    idle();
    rst = 1'b0;
    #1;

    // Forwarding priority and x0 suppression.
    reg_write_m = 1'b1; rd_m = 5'd5; reg_write_w = 1'b1; rd_w = 5'd5;
    rs1_e = 5'd5; rs2_e = 5'd5;
    #1;
    check("fwd_mw_a", forward_a_e, 2'b10);
    check("fwd_mw_b", forward_b_e, 2'b10);
    rd_m = 5'd0;
    #1;
    check("fwd_w_a", forward_a_e, 2'b01);
    check("fwd_w_b", forward_b_e, 2'b01);
    rd_m = 5'd5; rs1_e = 5'd0;
    #1;
    check("fwd_x0_a", forward_a_e, 2'b00);
    check("fwd_x0_b", forward_b_e, 2'b10);
    rd_w = 5'd3; rs2_e = 5'd3;
    #1;
    check("fwd_w_only_b", forward_b_e, 2'b01);
    idle();
    step();

    // Load-use: one stall cycle.
    load_use();
    #1;
    check("lu_stall_f", stall_f, 1'b1);
    check("lu_stall_d", stall_d, 1'b1);
    check("lu_flush_e", flush_e, 1'b1);
    check("lu_flush_d", flush_d, 1'b0);
    check("lu_stall_e", stall_e, 1'b0);
    step();
    idle();
    #1;
    check("lu_clear_stall", stall_f, 1'b0);
    check("lu_clear_flush", flush_e, 1'b0);
    check("lu_stall_cnt", stall_count, 1);

    // Branch overrides load-use stall.
    load_use(); pc_src_e = 1'b1;
    #1;
    check("br_flush_d", flush_d, 1'b1);
    check("br_flush_e", flush_e, 1'b1);
    check("br_stall_f", stall_f, 1'b0);
    check("br_stall_d", stall_d, 1'b0);
    step();
    idle();
    #1;
    check("br_flush_cnt", flush_count, 1);
    check("br_stall_cnt", stall_count, 1);

    // Multi-cycle: start at cycle 0, done at cycle 4.
    mc_start_e = 1'b1;
    #1;
    check("mc_c0_stall_f", stall_f, 1'b1);
    check("mc_c0_stall_e", stall_e, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      step();
      mc_start_e = 1'b0;
      pc_src_e = (c == 2);
      #1;
      check("mc_wait_stall_f", stall_f, 1'b1);
      check("mc_wait_stall_e", stall_e, 1'b1);
      check("mc_wait_flush_d", flush_d, 1'b0);
    end
    step();
    pc_src_e = 1'b0; mc_done_e = 1'b1;
    #1;
    check("mc_done_stall_f", stall_f, 1'b0);
    check("mc_done_stall_e", stall_e, 1'b0);
    step();
    mc_done_e = 1'b0;
    #1;
    check("mc_run_stall_f", stall_f, 1'b0);
    check("mc_stall_cnt", stall_count, 5);
    check("mc_flush_cnt", flush_count, 1);
    check("mc_no_error", mc_error, 1'b0);

    // Timeout: no done, error pulse 9 cycles after start.
    mc_start_e = 1'b1;
    #1;
    for (int c = 1; c <= 8; c++) begin
      step();
      mc_start_e = 1'b0;
      #1;
      check("to_wait_stall_f", stall_f, 1'b1);
      check("to_wait_no_err", mc_error, 1'b0);
    end
    step();
    check("to_error_pulse", mc_error, 1'b1);
    check("to_run_stall_f", stall_f, 1'b0);
    step();
    check("to_error_drop", mc_error, 1'b0);
    check("to_stall_cnt", stall_count, 14);

    // Done on the final wait cycle beats the timeout.
    mc_start_e = 1'b1;
    #1;
    for (int c = 1; c <= 7; c++) begin
      step();
      mc_start_e = 1'b0;
      #1;
    end
    step();
    mc_done_e = 1'b1;
    #1;
    check("late_done_stall_f", stall_f, 1'b0);
    step();
    mc_done_e = 1'b0;
    #1;
    check("late_done_no_err", mc_error, 1'b0);
    check("late_done_stall_cnt", stall_count, 22);

    // Reset in the middle of a wait.
    mc_start_e = 1'b1;
    #1;
    for (int c = 1; c <= 3; c++) begin
      step();
      mc_start_e = 1'b0;
      #1;
    end
    rst = 1'b1;
    #1;
    check("rst_mid_stall_f", stall_f, 1'b0);
    check("rst_mid_stall_e", stall_e, 1'b0);
    step();
    rst = 1'b0;
    #1;
    check("rst_mid_run", stall_f, 1'b0);
    check("rst_mid_stall_cnt", stall_count, 0);
    check("rst_mid_flush_cnt", flush_count, 0);
    check("rst_mid_mc_error", mc_error, 1'b0);

    // Saturation on the 2-bit counter instance.
    load_use();
    for (int c = 0; c < 5; c++) begin
      step();
    end
    idle();
    #1;
    check("sat_stall_cnt", s_stall_count, 2'b11);
    check("sat_main_cnt", stall_count, 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
